// File: rtl/lm07_pkg.sv
// Shared LM07 definitions for the serial read master and the responder.
// Frame geometry, temperature clamp and the responder state encoding.
package lm07_pkg;

    localparam int         LM07_FRAME_BITS = 16;
    localparam int         LM07_WORD_BITS  = 16;
    localparam logic [6:0] LM07_TEMP_MAX   = 7'd99;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_OVERRUN
    } lm07_state_e;

    typedef struct packed {
        logic       sign;
        logic [6:0] mag;
    } lm07_temp_t;

    function automatic lm07_temp_t lm07_clamp(
        input logic       sign,
        input logic [6:0] mag,
        input logic [6:0] max
    );
        lm07_temp_t t;
        t.sign = sign;
        t.mag  = (mag > max) ? max : mag;
        return t;
    endfunction

endpackage

// File: rtl/lm07_responder_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin with registered
// rise/fall pulses derived from the synchronized level and a history flop.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic SYSCLK,
    input  logic RST,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Clearing to 0 means a pin already low at reset release gives no fall.
    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], sig};
            hist_q <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~hist_q;
            fall   <= ~sync_q[STAGES-1] & hist_q;
        end
    end

endmodule

// File: rtl/lm07_responder.sv
// LM07 serial responder: oversamples CS/SCK on SYSCLK and shifts a
// {sign, magnitude, trail byte} frame out on SIO, MSB first.
module lm07_responder
    import lm07_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         FRAME_BITS  = LM07_FRAME_BITS,
    parameter logic [7:0] TRAIL_BYTE  = 8'h00,
    parameter logic [6:0] TEMP_MAX    = LM07_TEMP_MAX
) (
    input  logic       SYSCLK,
    input  logic       RST,
    input  logic       CS,
    input  logic       SCK,
    output logic       SIO,
    output logic       SIO_OE,
    input  logic       TEMP_SIGN,
    input  logic [6:0] TEMP_MAG,
    input  logic       TEMP_LOAD,
    output logic       FRAME_DONE,
    output logic [4:0] BIT_CNT
);

    localparam int         W        = LM07_WORD_BITS;
    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS);

    logic cs_rise;
    logic cs_fall;
    logic sck_rise;
    logic sck_fall;

    lm07_state_e state_q;
    lm07_state_e state_nxt;
    lm07_temp_t  pend_q;
    logic [W-1:0] shreg_q;
    logic [W-1:0] shreg_nxt;
    logic         sio_nxt;
    logic         oe_nxt;
    logic         done_nxt;
    logic [4:0]   cnt_nxt;

    sync_edge #(
        .STAGES(SYNC_STAGES)
    ) u_cs_sync (
        .SYSCLK(SYSCLK),
        .RST   (RST),
        .sig   (CS),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge #(
        .STAGES(SYNC_STAGES)
    ) u_sck_sync (
        .SYSCLK(SYSCLK),
        .RST   (RST),
        .sig   (SCK),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            pend_q <= '0;
        end else if (TEMP_LOAD) begin
            pend_q <= lm07_clamp(TEMP_SIGN, TEMP_MAG, TEMP_MAX);
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            SIO        <= 1'b0;
            SIO_OE     <= 1'b0;
            FRAME_DONE <= 1'b0;
            BIT_CNT    <= '0;
        end else begin
            state_q    <= state_nxt;
            shreg_q    <= shreg_nxt;
            SIO        <= sio_nxt;
            SIO_OE     <= oe_nxt;
            FRAME_DONE <= done_nxt;
            BIT_CNT    <= cnt_nxt;
        end
    end

    // cs_rise wins over any SCK edge in the same cycle.
    always_comb begin
        state_nxt = state_q;
        shreg_nxt = shreg_q;
        sio_nxt   = SIO;
        oe_nxt    = SIO_OE;
        done_nxt  = 1'b0;
        cnt_nxt   = BIT_CNT;
        if (cs_rise) begin
            state_nxt = ST_IDLE;
            oe_nxt    = 1'b0;
            sio_nxt   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    oe_nxt  = 1'b0;
                    sio_nxt = 1'b0;
                    if (cs_fall) begin
                        shreg_nxt = {pend_q.sign, pend_q.mag, TRAIL_BYTE};
                        cnt_nxt   = '0;
                        state_nxt = ST_DRIVE;
                        oe_nxt    = 1'b1;
                        sio_nxt   = pend_q.sign;
                    end
                end
                ST_DRIVE: begin
                    oe_nxt = 1'b1;
                    if (sck_rise) begin
                        cnt_nxt = BIT_CNT + 5'd1;
                    end else if (sck_fall) begin
                        shreg_nxt = {shreg_q[W-2:0], 1'b0};
                    end
                    sio_nxt = shreg_nxt[W-1];
                    if (sck_rise && cnt_nxt == LAST_BIT) begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_OVERRUN;
                        sio_nxt   = 1'b0;
                    end
                end
                ST_OVERRUN: begin
                    oe_nxt  = 1'b1;
                    sio_nxt = 1'b0;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    oe_nxt    = 1'b0;
                    sio_nxt   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lm07_responder.sv
// Bench for lm07_responder: table of fixed reads, hand-built corner
// sequences and randomized reads against a frame-level reference model.
module tb_lm07_responder;

    logic       SYSCLK;
    logic       RST;
    logic       CS;
    logic       SCK;
    logic       SIO;
    logic       SIO_OE;
    logic       TEMP_SIGN;
    logic [6:0] TEMP_MAG;
    logic       TEMP_LOAD;
    logic       FRAME_DONE;
    logic [4:0] BIT_CNT;

    int n_chk;
    int n_fail;
    int done_cnt;

    logic       m_sign;
    logic [6:0] m_mag;

    typedef struct {
        logic        sign;
        logic [6:0]  mag;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[8];

    lm07_responder dut (
        .SYSCLK    (SYSCLK),
        .RST       (RST),
        .CS        (CS),
        .SCK       (SCK),
        .SIO       (SIO),
        .SIO_OE    (SIO_OE),
        .TEMP_SIGN (TEMP_SIGN),
        .TEMP_MAG  (TEMP_MAG),
        .TEMP_LOAD (TEMP_LOAD),
        .FRAME_DONE(FRAME_DONE),
        .BIT_CNT   (BIT_CNT)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    always @(negedge SYSCLK) begin
        if (FRAME_DONE) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge SYSCLK);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic s, input logic [6:0] m);
        TEMP_SIGN = s;
        TEMP_MAG  = m;
        TEMP_LOAD = 1'b1;
        tick(1);
        TEMP_LOAD = 1'b0;
        m_sign = s;
        m_mag  = (m > 7'd99) ? 7'd99 : m;
    endtask

    function automatic logic [19:0] model_bits(input int nbits);
        logic [15:0] word;
        logic [19:0] r;
        word = {m_sign, m_mag, 8'h00};
        r = '0;
        for (int i = 0; i < nbits; i++)
            r = {r[18:0], (i < 16) ? word[15 - i] : 1'b0};
        return r;
    endfunction

    task automatic do_read(input int nbits, input int load_at,
                           input logic [6:0] lmag,
                           output logic [19:0] cap, output int dones);
        int d0;
        cap = '0;
        chk("oe_before_cs", SIO_OE, 0);
        d0 = done_cnt;
        CS = 1'b0;
        tick(6);
        for (int i = 0; i < nbits; i++) begin
            cap = {cap[18:0], SIO};
            SCK = 1'b1;
            tick(8);
            if (i == load_at) load(1'b0, lmag);
            SCK = 1'b0;
            tick(8);
        end
        tick(2);
        chk("oe_in_frame", SIO_OE, 1);
        CS = 1'b1;
        tick(4);
        chk("oe_after_cs", SIO_OE, 0);
        tick(4);
        dones = done_cnt - d0;
    endtask

    logic [19:0] cap;
    logic [19:0] exp_bits;
    int          dn;
    int          nb;

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        done_cnt  = 0;
        m_sign    = 1'b0;
        m_mag     = '0;
        RST       = 1'b1;
        CS        = 1'b1;
        SCK       = 1'b0;
        TEMP_SIGN = 1'b0;
        TEMP_MAG  = '0;
        TEMP_LOAD = 1'b0;

        tbl[0] = '{1'b0, 7'd25,  16'h1900};
        tbl[1] = '{1'b1, 7'd12,  16'h8C00};
        tbl[2] = '{1'b0, 7'd120, 16'h6300};
        tbl[3] = '{1'b0, 7'd99,  16'h6300};
        tbl[4] = '{1'b0, 7'd100, 16'h6300};
        tbl[5] = '{1'b1, 7'd127, 16'hE300};
        tbl[6] = '{1'b0, 7'd0,   16'h0000};
        tbl[7] = '{1'b1, 7'd1,   16'h8100};

        tick(3);
        RST = 1'b0;
        tick(6);
        chk("rst_sio", SIO, 0);
        chk("rst_oe", SIO_OE, 0);
        chk("rst_done", FRAME_DONE, 0);
        chk("rst_cnt", BIT_CNT, 0);

        // Pending register is zero after reset.
        do_read(16, -1, 7'd0, cap, dn);
        chk("rst_word", cap[15:0], 16'h0000);

        foreach (tbl[k]) begin
            load(tbl[k].sign, tbl[k].mag);
            do_read(16, -1, 7'd0, cap, dn);
            chk("tbl_word", cap[15:0], tbl[k].exp);
            chk("tbl_done", dn, 1);
            chk("tbl_cnt", BIT_CNT, 16);
        end

        // Abort after 5 bits with a load mid-frame.
        load(1'b0, 7'd25);
        do_read(5, 2, 7'd40, cap, dn);
        chk("abort_bits", cap[4:0], 5'b00011);
        chk("abort_done", dn, 0);
        chk("abort_cnt", BIT_CNT, 5);
        do_read(16, -1, 7'd0, cap, dn);
        chk("after_abort", cap[15:0], 16'h2800);

        // Overrun: 20 clocks in one frame.
        load(1'b0, 7'd25);
        do_read(20, -1, 7'd0, cap, dn);
        chk("ovr_word", cap[19:4], 16'h1900);
        chk("ovr_tail", cap[3:0], 4'h0);
        chk("ovr_cnt", BIT_CNT, 16);
        chk("ovr_done", dn, 1);

        // Reset mid-frame with CS still low at release.
        load(1'b1, 7'd50);
        CS = 1'b0;
        tick(6);
        for (int i = 0; i < 8; i++) begin
            SCK = 1'b1;
            tick(8);
            SCK = 1'b0;
            tick(8);
        end
        chk("pre_rst_cnt", BIT_CNT, 8);
        RST = 1'b1;
        tick(1);
        chk("rst_mid_oe", SIO_OE, 0);
        chk("rst_mid_cnt", BIT_CNT, 0);
        RST = 1'b0;
        m_sign = 1'b0;
        m_mag  = '0;
        tick(8);
        chk("cs_low_idle", SIO_OE, 0);
        CS = 1'b1;
        tick(8);
        do_read(16, -1, 7'd0, cap, dn);
        chk("post_rst_word", cap[15:0], 16'h0000);

        // Randomized reads against the frame model.
        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 3) != 0)
                load(1'($urandom), 7'($urandom_range(0, 127)));
            nb = $urandom_range(1, 20);
            exp_bits = model_bits(nb);
            do_read(nb, -1, 7'd0, cap, dn);
            chk("rnd_bits", cap, exp_bits);
            chk("rnd_done", dn, (nb >= 16) ? 1 : 0);
            chk("rnd_cnt", BIT_CNT, (nb >= 16) ? 16 : nb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
